song_sequencer: RTL and testbench

- Sequences the 128x16 song ROM: generates `rom_addr`, absorbs the ROM's 1-cycle registered read latency, and decodes each entry.
- Dispatches note events to a bank of note-player voices and times advance entries against the system beat tick.
- Sits between the user controls (play/restart/song select) and the song ROM plus voice bank.
- ROM entry format: [15] advance, [14:9] note, [8:3] duration in beats, [2:0] meta.

---
 rtl/song_sequencer_pkg.sv | 32 +++
 rtl/song_sequencer_voice_allocator.sv | 44 ++++
 rtl/song_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_song_sequencer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/song_sequencer_pkg.sv
// Shared types and ROM word layout for the song sequencer.
package song_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_ROM,
        ST_DECODE,
        ST_DISPATCH,
        ST_ADVANCE,
        ST_WAIT_BEAT,
        ST_NEXT,
        ST_DONE
    } state_t;

    localparam int ADDR_W   = 7;
    localparam int ROM_W    = 16;
    localparam int FIELD_W  = 6;
    localparam int META_W   = 3;

    // ROM word: [15] advance, [14:9] note, [8:3] duration (beats), [2:0] meta
    localparam int ADV_BIT  = 15;
    localparam int NOTE_MSB = 14;
    localparam int NOTE_LSB = 9;
    localparam int DUR_MSB  = 8;
    localparam int DUR_LSB  = 3;
    localparam int META_MSB = 2;
    localparam int META_LSB = 0;

    localparam logic [FIELD_W-1:0] NOTE_REST = '0;

endpackage

// File: rtl/song_sequencer_voice_allocator.sv
// Lowest-index free voice picker. Build option VOICE_STEAL_EN adds a
// round-robin steal pointer used when every voice is busy.
module voice_allocator #(
    parameter int NUM_VOICES = 3
) (
`ifdef VOICE_STEAL_EN
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_steal,
`endif
    input  logic [NUM_VOICES-1:0] i_voice_busy,
    output logic [NUM_VOICES-1:0] o_grant,
    output logic                  o_any_free
);

    logic [NUM_VOICES-1:0] w_free;
    logic [NUM_VOICES-1:0] w_lowest;

    // isolate the lowest set bit of the free mask
    assign w_free     = ~i_voice_busy;
    assign w_lowest   = w_free & (~w_free + NUM_VOICES'(1));
    assign o_any_free = |w_free;

`ifdef VOICE_STEAL_EN
    localparam int PTR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic [PTR_W-1:0] r_steal_ptr;

    // advance the steal pointer each time a busy voice is taken over
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_steal_ptr <= '0;
        end else if (i_steal) begin
            r_steal_ptr <= (r_steal_ptr == PTR_W'(NUM_VOICES - 1)) ? '0
                                                                   : r_steal_ptr + PTR_W'(1);
        end
    end

    assign o_grant = o_any_free ? w_lowest : (NUM_VOICES'(1) << r_steal_ptr);
`else
    assign o_grant = w_lowest;
`endif

endmodule

// File: rtl/song_sequencer.sv
// Song ROM sequencer: fetches entries, dispatches notes to voices and
// times advance entries against the beat tick.
// Build option VOICE_STEAL_EN: steal a busy voice instead of stalling dispatch.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for play; song_sel latched on exit
// FETCH     | rom_addr = {song, entry} presented to the ROM
// WAIT_ROM  | ROM read latency; entry word captured at end of cycle
// DECODE    | rest entries skip dispatch
// DISPATCH  | load a voice (stalls while none free unless stealing)
// ADVANCE   | decide whether to wait on beats
// WAIT_BEAT | count down duration on beat while playing
// NEXT      | step entry (gated by play) or finish at last entry
// DONE      | song_done high until restart
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int SONG_BITS  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_play,
    input  logic                  i_restart,
    input  logic [SONG_BITS-1:0]  i_song_sel,
    input  logic                  i_beat,
    output logic [ADDR_W-1:0]     o_rom_addr,
    input  logic [ROM_W-1:0]      i_rom_dout,
    output logic [NUM_VOICES-1:0] o_voice_load,
    output logic [FIELD_W-1:0]    o_voice_note,
    output logic [FIELD_W-1:0]    o_voice_duration,
    output logic [META_W-1:0]     o_voice_meta,
    input  logic [NUM_VOICES-1:0] i_voice_busy,
    output logic                  o_song_done
);

    localparam int ENTRY_W = ADDR_W - SONG_BITS;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SONG_BITS-1:0]  r_song;
    logic [ENTRY_W-1:0]    r_entry;
    logic [ENTRY_W-1:0]    w_entry_inc;
    logic [ROM_W-1:0]      r_word;
    logic [FIELD_W-1:0]    r_beat_cnt;
    logic [ADDR_W-1:0]     r_rom_addr;
    logic [NUM_VOICES-1:0] r_voice_load;
    logic [FIELD_W-1:0]    r_voice_note;
    logic [FIELD_W-1:0]    r_voice_duration;
    logic [META_W-1:0]     r_voice_meta;

    logic                  w_adv;
    logic [FIELD_W-1:0]    w_note;
    logic [FIELD_W-1:0]    w_dur;
    logic [META_W-1:0]     w_meta;
    logic                  w_entry_last;
    logic                  w_beat_last;
    logic                  w_wait_needed;
    logic [NUM_VOICES-1:0] w_grant;
    logic                  w_any_free;
    logic                  w_load_ok;

    assign w_adv         = r_word[ADV_BIT];
    assign w_note        = r_word[NOTE_MSB:NOTE_LSB];
    assign w_dur         = r_word[DUR_MSB:DUR_LSB];
    assign w_meta        = r_word[META_MSB:META_LSB];
    assign w_entry_last  = &r_entry;
    assign w_entry_inc   = r_entry + ENTRY_W'(1);
    assign w_beat_last   = i_beat && i_play && (r_beat_cnt == FIELD_W'(1));
    assign w_wait_needed = w_adv && (w_dur != '0);

`ifdef VOICE_STEAL_EN
    logic w_steal;

    assign w_steal   = (r_state == ST_DISPATCH) && !w_any_free && !i_restart;
    assign w_load_ok = 1'b1;

    voice_allocator #(.NUM_VOICES(NUM_VOICES)) u_alloc (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_steal      (w_steal),
        .i_voice_busy (i_voice_busy),
        .o_grant      (w_grant),
        .o_any_free   (w_any_free)
    );
`else
    assign w_load_ok = w_any_free;

    voice_allocator #(.NUM_VOICES(NUM_VOICES)) u_alloc (
        .i_voice_busy (i_voice_busy),
        .o_grant      (w_grant),
        .o_any_free   (w_any_free)
    );
`endif

    // state register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state decode; restart overrides every transition
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:      if (i_play) w_state_nxt = ST_FETCH;
            ST_FETCH:     w_state_nxt = ST_WAIT_ROM;
            ST_WAIT_ROM:  w_state_nxt = ST_DECODE;
            ST_DECODE:    w_state_nxt = (w_note == NOTE_REST) ? ST_ADVANCE : ST_DISPATCH;
            ST_DISPATCH:  if (w_load_ok) w_state_nxt = ST_ADVANCE;
            ST_ADVANCE:   w_state_nxt = w_wait_needed ? ST_WAIT_BEAT : ST_NEXT;
            ST_WAIT_BEAT: if (w_beat_last) w_state_nxt = ST_NEXT;
            ST_NEXT: begin
                if (w_entry_last)  w_state_nxt = ST_DONE;
                else if (i_play)   w_state_nxt = ST_FETCH;
            end
            ST_DONE:      w_state_nxt = ST_DONE;
            default:      w_state_nxt = ST_IDLE;
        endcase
        if (i_restart) w_state_nxt = ST_IDLE;
    end

    // datapath: address, entry word, beat counter and voice outputs
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_song           <= '0;
            r_entry          <= '0;
            r_word           <= '0;
            r_beat_cnt       <= '0;
            r_rom_addr       <= '0;
            r_voice_load     <= '0;
            r_voice_note     <= '0;
            r_voice_duration <= '0;
            r_voice_meta     <= '0;
        end else begin
            r_voice_load <= '0;
            if (i_restart) begin
                r_entry    <= '0;
                r_beat_cnt <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_play) begin
                            r_song     <= i_song_sel;
                            r_entry    <= '0;
                            r_rom_addr <= {i_song_sel, ENTRY_W'(0)};
                        end
                    end
                    ST_WAIT_ROM: r_word <= i_rom_dout;
                    ST_DISPATCH: begin
                        if (w_load_ok) begin
                            r_voice_load     <= w_grant;
                            r_voice_note     <= w_note;
                            r_voice_duration <= w_dur;
                            r_voice_meta     <= w_meta;
                        end
                    end
                    ST_ADVANCE: begin
                        if (w_wait_needed) r_beat_cnt <= w_dur;
                    end
                    ST_WAIT_BEAT: begin
                        if (i_beat && i_play) r_beat_cnt <= r_beat_cnt - FIELD_W'(1);
                    end
                    ST_NEXT: begin
                        if (!w_entry_last && i_play) begin
                            r_entry    <= w_entry_inc;
                            r_rom_addr <= {r_song, w_entry_inc};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_rom_addr       = r_rom_addr;
    assign o_voice_load     = r_voice_load;
    assign o_voice_note     = r_voice_note;
    assign o_voice_duration = r_voice_duration;
    assign o_voice_meta     = r_voice_meta;
    assign o_song_done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a registered ROM model.
module tb_song_sequencer;

    logic        clk;
    logic        reset_n;
    logic        play;
    logic        restart;
    logic [1:0]  song_sel;
    logic        beat;
    logic [6:0]  rom_addr;
    logic [15:0] rom_dout;
    logic [2:0]  voice_load;
    logic [5:0]  voice_note;
    logic [5:0]  voice_duration;
    logic [2:0]  voice_meta;
    logic [2:0]  voice_busy;
    logic        song_done;

    logic [15:0] rom [0:127];

    int checks = 0;
    int errors = 0;

    song_sequencer #(.NUM_VOICES(3), .SONG_BITS(2)) dut (
        .i_clk            (clk),
        .i_reset_n        (reset_n),
        .i_play           (play),
        .i_restart        (restart),
        .i_song_sel       (song_sel),
        .i_beat           (beat),
        .o_rom_addr       (rom_addr),
        .i_rom_dout       (rom_dout),
        .o_voice_load     (voice_load),
        .o_voice_note     (voice_note),
        .o_voice_duration (voice_duration),
        .o_voice_meta     (voice_meta),
        .i_voice_busy     (voice_busy),
        .o_song_done      (song_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_dout <= rom[rom_addr];

    function automatic logic [15:0] mk(input logic adv, input logic [5:0] note,
                                       input logic [5:0] dur, input logic [2:0] meta);
        return {adv, note, dur, meta};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_beat();
        beat = 1'b1;
        tick();
        beat = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        checks++;
        if (rom_addr !== 7'd0 || voice_load !== 3'b000 || song_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got addr=%0d load=%b done=%b required 0/000/0",
                     rom_addr, voice_load, song_done);
        end
        checks++;
        if (voice_note !== 6'd0 || voice_duration !== 6'd0 || voice_meta !== 3'd0) begin
            errors++;
            $display("FAIL reset_fields: got note=%0d dur=%0d meta=%0d required 0",
                     voice_note, voice_duration, voice_meta);
        end
        reset_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (rom_addr !== 7'd0 || voice_load !== 3'b000) begin
            errors++;
            $display("FAIL idle_no_play: got addr=%0d load=%b required 0/000", rom_addr, voice_load);
        end
    endtask

    task automatic test_first_entry();
        play = 1'b1;
        tick();
        checks++;
        if (rom_addr !== 7'd0) begin
            errors++;
            $display("FAIL first_fetch_addr: got %0d required 0", rom_addr);
        end
        repeat (3) tick();
        checks++;
        if (voice_load !== 3'b000) begin
            errors++;
            $display("FAIL early_load: got %b required 000", voice_load);
        end
        tick();
        checks++;
        if (voice_load !== 3'b001 || voice_note !== 6'd49 || voice_duration !== 6'd12 ||
            voice_meta !== 3'd7) begin
            errors++;
            $display("FAIL dispatch_entry0: got load=%b note=%0d dur=%0d meta=%0d required 001/49/12/7",
                     voice_load, voice_note, voice_duration, voice_meta);
        end
        tick();
        checks++;
        if (voice_load !== 3'b000) begin
            errors++;
            $display("FAIL load_pulse_width: got %b required 000", voice_load);
        end
        tick();
        checks++;
        if (rom_addr !== 7'd1) begin
            errors++;
            $display("FAIL no_beat_wait: got addr=%0d required 1", rom_addr);
        end
    endtask

    task automatic test_beat_wait();
        repeat (4) tick();
        checks++;
        if (voice_load !== 3'b001 || voice_note !== 6'd1) begin
            errors++;
            $display("FAIL dispatch_entry1: got load=%b note=%0d required 001/1", voice_load, voice_note);
        end
        tick();
        repeat (11) pulse_beat();
        repeat (2) tick();
        checks++;
        if (rom_addr !== 7'd1) begin
            errors++;
            $display("FAIL eleven_beats: got addr=%0d required 1", rom_addr);
        end
        pulse_beat();
        tick();
        checks++;
        if (rom_addr !== 7'd2) begin
            errors++;
            $display("FAIL twelve_beats: got addr=%0d required 2", rom_addr);
        end
    endtask

    task automatic test_rest_pause();
        logic [2:0] seen;
        seen = 3'b000;
        repeat (4) begin
            tick();
            seen |= voice_load;
        end
        checks++;
        if (seen !== 3'b000) begin
            errors++;
            $display("FAIL rest_no_load: got %b required 000", seen);
        end
        repeat (5) pulse_beat();
        play = 1'b0;
        repeat (10) pulse_beat();
        play = 1'b1;
        repeat (6) pulse_beat();
        repeat (2) tick();
        checks++;
        if (rom_addr !== 7'd2) begin
            errors++;
            $display("FAIL pause_counter_held: got addr=%0d required 2", rom_addr);
        end
        pulse_beat();
        tick();
        checks++;
        if (rom_addr !== 7'd3) begin
            errors++;
            $display("FAIL pause_counter_final: got addr=%0d required 3", rom_addr);
        end
    endtask

    task automatic test_full_bank();
        voice_busy = 3'b111;
        repeat (4) tick();
`ifdef VOICE_STEAL_EN
        checks++;
        if (voice_load !== 3'b001 || voice_note !== 6'd5 || voice_meta !== 3'd2) begin
            errors++;
            $display("FAIL steal_first: got load=%b note=%0d meta=%0d required 001/5/2",
                     voice_load, voice_note, voice_meta);
        end
`else
        checks++;
        if (voice_load !== 3'b000) begin
            errors++;
            $display("FAIL stall_load: got %b required 000", voice_load);
        end
        tick();
        checks++;
        if (voice_load !== 3'b000) begin
            errors++;
            $display("FAIL stall_hold: got %b required 000", voice_load);
        end
        voice_busy = 3'b101;
        tick();
        checks++;
        if (voice_load !== 3'b010 || voice_note !== 6'd5 || voice_meta !== 3'd2) begin
            errors++;
            $display("FAIL stall_release: got load=%b note=%0d meta=%0d required 010/5/2",
                     voice_load, voice_note, voice_meta);
        end
        voice_busy = 3'b000;
`endif
        for (int i = 0; i < 30 && rom_addr !== 7'd4; i++) tick();
        checks++;
        if (rom_addr !== 7'd4) begin
            errors++;
            $display("FAIL reach_entry4: got addr=%0d required 4", rom_addr);
        end
        repeat (4) tick();
`ifdef VOICE_STEAL_EN
        checks++;
        if (voice_load !== 3'b010 || voice_note !== 6'd6) begin
            errors++;
            $display("FAIL steal_second: got load=%b note=%0d required 010/6", voice_load, voice_note);
        end
`else
        checks++;
        if (voice_load !== 3'b001 || voice_note !== 6'd6) begin
            errors++;
            $display("FAIL free_second: got load=%b note=%0d required 001/6", voice_load, voice_note);
        end
`endif
        voice_busy = 3'b000;
    endtask

    task automatic test_restart_wait();
        for (int i = 0; i < 30 && rom_addr !== 7'd5; i++) tick();
        checks++;
        if (rom_addr !== 7'd5) begin
            errors++;
            $display("FAIL reach_entry5: got addr=%0d required 5", rom_addr);
        end
        repeat (4) tick();
        checks++;
        if (voice_load !== 3'b001 || voice_note !== 6'd7) begin
            errors++;
            $display("FAIL dispatch_entry5: got load=%b note=%0d required 001/7", voice_load, voice_note);
        end
        tick();
        repeat (2) pulse_beat();
        play    = 1'b0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        checks++;
        if (voice_load !== 3'b000 || song_done !== 1'b0 || rom_addr !== 7'd5) begin
            errors++;
            $display("FAIL restart_state: got load=%b done=%b addr=%0d required 000/0/5",
                     voice_load, song_done, rom_addr);
        end
        repeat (3) pulse_beat();
        repeat (2) tick();
        checks++;
        if (rom_addr !== 7'd5) begin
            errors++;
            $display("FAIL restart_idle: got addr=%0d required 5", rom_addr);
        end
        play = 1'b1;
        tick();
        checks++;
        if (rom_addr !== 7'd0) begin
            errors++;
            $display("FAIL replay_entry0: got addr=%0d required 0", rom_addr);
        end
    endtask

    task automatic test_song_end();
        logic wrong_song;
        restart = 1'b1;
        play    = 1'b0;
        tick();
        restart  = 1'b0;
        song_sel = 2'd3;
        play     = 1'b1;
        tick();
        checks++;
        if (rom_addr !== 7'd96) begin
            errors++;
            $display("FAIL song3_start: got addr=%0d required 96", rom_addr);
        end
        song_sel   = 2'd1;
        wrong_song = 1'b0;
        for (int i = 0; i < 400 && song_done !== 1'b1; i++) begin
            tick();
            if (rom_addr[6:5] !== 2'd3) wrong_song = 1'b1;
        end
        checks++;
        if (song_done !== 1'b1 || rom_addr !== 7'd127) begin
            errors++;
            $display("FAIL song_done: got done=%b addr=%0d required 1/127", song_done, rom_addr);
        end
        checks++;
        if (wrong_song !== 1'b0) begin
            errors++;
            $display("FAIL song_sel_midsong: got wrong_song=%b required 0", wrong_song);
        end
        repeat (3) tick();
        checks++;
        if (song_done !== 1'b1 || rom_addr !== 7'd127) begin
            errors++;
            $display("FAIL done_hold: got done=%b addr=%0d required 1/127", song_done, rom_addr);
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        checks++;
        if (song_done !== 1'b0 || rom_addr !== 7'd127) begin
            errors++;
            $display("FAIL done_restart: got done=%b addr=%0d required 0/127", song_done, rom_addr);
        end
        tick();
        checks++;
        if (rom_addr !== 7'd32) begin
            errors++;
            $display("FAIL song1_start: got addr=%0d required 32", rom_addr);
        end
    endtask

    task automatic test_async_reset();
        repeat (4) tick();
        checks++;
        if (voice_load !== 3'b001 || voice_note !== 6'd9 || voice_duration !== 6'd1) begin
            errors++;
            $display("FAIL dispatch_song1: got load=%b note=%0d dur=%0d required 001/9/1",
                     voice_load, voice_note, voice_duration);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (voice_load !== 3'b000 || voice_note !== 6'd0 || voice_duration !== 6'd0 ||
            voice_meta !== 3'd0 || rom_addr !== 7'd0 || song_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got load=%b note=%0d dur=%0d meta=%0d addr=%0d done=%b required zeros",
                     voice_load, voice_note, voice_duration, voice_meta, rom_addr, song_done);
        end
        play = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (2) tick();
        checks++;
        if (rom_addr !== 7'd0 || voice_load !== 3'b000) begin
            errors++;
            $display("FAIL post_reset_idle: got addr=%0d load=%b required 0/000", rom_addr, voice_load);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        rom[0]  = mk(1'b0, 6'd49, 6'd12, 3'b111);
        rom[1]  = mk(1'b1, 6'd1,  6'd12, 3'b111);
        rom[2]  = mk(1'b1, 6'd0,  6'd12, 3'b011);
        rom[3]  = mk(1'b0, 6'd5,  6'd1,  3'b010);
        rom[4]  = mk(1'b0, 6'd6,  6'd1,  3'b011);
        rom[5]  = mk(1'b1, 6'd7,  6'd10, 3'b001);
        rom[32] = mk(1'b0, 6'd9,  6'd1,  3'b000);

        reset_n    = 1'b0;
        play       = 1'b0;
        restart    = 1'b0;
        song_sel   = 2'd0;
        beat       = 1'b0;
        voice_busy = 3'b000;

        test_reset();
        test_first_entry();
        test_beat_wait();
        test_rest_pause();
        test_full_bank();
        test_restart_wait();
        test_song_end();
        test_async_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
